// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect/trap requests in, fetch PC and status out.
// The master modport is the PC generator; the slave modport is its environment.
interface pc_gen_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  stall;
    logic                  fetch_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  trap_valid;
    logic [ADDR_WIDTH-1:0] trap_vector;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  pc_valid;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] fault_addr;
    logic [CNT_WIDTH-1:0]  redirect_count;

    modport master (
        input  stall,
        input  fetch_ready,
        input  redirect_valid,
        input  redirect_target,
        input  trap_valid,
        input  trap_vector,
        output pc_out,
        output pc_valid,
        output misaligned,
        output fault_addr,
        output redirect_count
    );

    modport slave (
        output stall,
        output fetch_ready,
        output redirect_valid,
        output redirect_target,
        output trap_valid,
        output trap_vector,
        input  pc_out,
        input  pc_valid,
        input  misaligned,
        input  fault_addr,
        input  redirect_count
    );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program counter: trap > redirect > sequential > hold, with a FAULT park
// on misaligned redirect targets and a saturating count of accepted redirects.
module pc_gen #(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned            INC_BYTES    = 4,
    parameter int unsigned            CNT_WIDTH    = 16
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Low address bits that must be zero for an INC_BYTES-aligned target.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INC_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] INC      = ADDR_WIDTH'(INC_BYTES);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic [ADDR_WIDTH-1:0] fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] trap_aligned;
    logic                  target_misaligned;
    logic                  advance;

    always_comb begin
        trap_aligned      = bus.trap_vector & ~LOW_MASK;
        target_misaligned = |(bus.redirect_target & LOW_MASK);
        advance           = valid_q && bus.fetch_ready && !bus.stall;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (bus.trap_valid) begin
                    pc_d    = trap_aligned;
                    valid_d = 1'b1;
                end else if (bus.redirect_valid && !target_misaligned) begin
                    pc_d    = bus.redirect_target;
                    valid_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else if (bus.redirect_valid) begin
                    state_d = ST_FAULT;
                    valid_d = 1'b0;
                    fault_d = bus.redirect_target;
                    mis_d   = 1'b1;
                end else if (advance) begin
                    pc_d = pc_q + INC;
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
                if (bus.trap_valid) begin
                    state_d = ST_RUN;
                    pc_d    = trap_aligned;
                    valid_d = 1'b1;
                end
            end
            default: begin
                // Unused encoding: recover through BOOT with fetch withheld.
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.pc_valid       = valid_q;
    assign bus.misaligned     = mis_q;
    assign bus.fault_addr     = fault_q;
    assign bus.redirect_count = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand sequences for wrap, reset and
// counter saturation, then random traffic against a behavioural model.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
    pc_gen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

    pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INC_BYTES(4), .CNT_WIDTH(16))
        dut (.clk(clk), .rst(rst), .bus(bus));
    pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INC_BYTES(4), .CNT_WIDTH(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          st, rd, rv;
        logic [31:0] rt;
        bit          tv;
        logic [31:0] tvec;
        logic [31:0] e_pc;
        bit          e_v, e_mis;
        logic [31:0] e_fa;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit st, bit rd, bit rv, logic [31:0] rt, bit tv,
                                logic [31:0] tvec, logic [31:0] pc, bit v, bit mis,
                                logic [31:0] fa, logic [15:0] cnt);
        vec_t r;
        r.st = st; r.rd = rd; r.rv = rv; r.rt = rt; r.tv = tv; r.tvec = tvec;
        r.e_pc = pc; r.e_v = v; r.e_mis = mis; r.e_fa = fa; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(string tag, logic [31:0] pc, bit v, bit mis,
                           logic [31:0] fa, logic [15:0] cnt);
        chk({tag, ".pc_out"},   64'(bus.pc_out),         64'(pc));
        chk({tag, ".pc_valid"}, 64'(bus.pc_valid),       64'(v));
        chk({tag, ".misalign"}, 64'(bus.misaligned),     64'(mis));
        chk({tag, ".fault"},    64'(bus.fault_addr),     64'(fa));
        chk({tag, ".count"},    64'(bus.redirect_count), 64'(cnt));
    endtask

    task automatic drive(bit st, bit rd, bit rv, logic [31:0] rt, bit tv, logic [31:0] tvec);
        bus.stall = st; bus.fetch_ready = rd; bus.redirect_valid = rv;
        bus.redirect_target = rt; bus.trap_valid = tv; bus.trap_vector = tvec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Behavioural model: spec rules expressed on plain integers.
    longint m_pc, m_fa, m_cnt;
    bit     m_boot, m_fault, m_v, m_mis;

    task automatic model_reset();
        m_pc = 0; m_fa = 0; m_cnt = 0; m_boot = 1; m_fault = 0; m_v = 0; m_mis = 0;
    endtask

    task automatic model_edge(bit st, bit rd, bit rv, longint rt, bit tv, longint tvec);
        bit adv;
        adv   = m_v && rd && !st;
        m_mis = 0;
        if (m_boot) begin
            m_boot = 0; m_v = 1;
        end else if (m_fault) begin
            if (tv) begin m_pc = tvec - (tvec % 4); m_fault = 0; m_v = 1; end
        end else if (tv) begin
            m_pc = tvec - (tvec % 4);
        end else if (rv && (rt % 4 == 0)) begin
            m_pc = rt;
            if (m_cnt < 65535) m_cnt++;
        end else if (rv) begin
            m_fault = 1; m_v = 0; m_fa = rt; m_mis = 1;
        end else if (adv) begin
            m_pc = (m_pc + 4) % (64'd1 << 32);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rt, tvec;
        bit st, rd, rv, tv;

        //       st rd rv  rt            tv tvec          pc            v mis fa            cnt
        tbl[0]  = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,        1, 0, 32'h0,   16'd0);
        tbl[1]  = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'h4,        1, 0, 32'h0,   16'd0);
        tbl[2]  = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'h8,        1, 0, 32'h0,   16'd0);
        tbl[3]  = mk(1, 1, 0, 32'h0,       0, 32'h0,   32'h8,        1, 0, 32'h0,   16'd0);
        tbl[4]  = mk(1, 1, 0, 32'h0,       0, 32'h0,   32'h8,        1, 0, 32'h0,   16'd0);
        tbl[5]  = mk(1, 1, 0, 32'h0,       0, 32'h0,   32'h8,        1, 0, 32'h0,   16'd0);
        tbl[6]  = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'hC,        1, 0, 32'h0,   16'd0);
        tbl[7]  = mk(0, 0, 0, 32'h0,       0, 32'h0,   32'hC,        1, 0, 32'h0,   16'd0);
        tbl[8]  = mk(0, 0, 0, 32'h0,       0, 32'h0,   32'hC,        1, 0, 32'h0,   16'd0);
        tbl[9]  = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'h10,       1, 0, 32'h0,   16'd0);
        tbl[10] = mk(1, 1, 1, 32'h100,     0, 32'h0,   32'h100,      1, 0, 32'h0,   16'd1);
        tbl[11] = mk(1, 1, 0, 32'h0,       0, 32'h0,   32'h100,      1, 0, 32'h0,   16'd1);
        tbl[12] = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'h104,      1, 0, 32'h0,   16'd1);
        tbl[13] = mk(0, 1, 1, 32'h102,     0, 32'h0,   32'h104,      0, 1, 32'h102, 16'd1);
        tbl[14] = mk(0, 1, 1, 32'h200,     0, 32'h0,   32'h104,      0, 0, 32'h102, 16'd1);
        tbl[15] = mk(0, 1, 0, 32'h0,       1, 32'h203, 32'h200,      1, 0, 32'h102, 16'd1);
        tbl[16] = mk(0, 1, 1, 32'h40,      1, 32'h80,  32'h80,       1, 0, 32'h102, 16'd1);
        tbl[17] = mk(0, 1, 0, 32'h0,       0, 32'h0,   32'h84,       1, 0, 32'h102, 16'd1);

        drive(0, 0, 0, 32'h0, 0, 32'h0);
        bus2.stall = 0; bus2.fetch_ready = 0; bus2.redirect_valid = 0;
        bus2.redirect_target = '0; bus2.trap_valid = 0; bus2.trap_vector = '0;

        rst = 1'b1;
        #3;
        chk_all("reset", 32'h0, 0, 0, 32'h0, 16'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].rv, tbl[i].rt, tbl[i].tv, tbl[i].tvec);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_mis,
                    tbl[i].e_fa, tbl[i].e_cnt);
        end

        // Wrap past the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
        step();
        chk_all("wrap_redir", 32'hFFFF_FFFC, 1, 0, 32'h102, 16'd2);
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        step();
        chk_all("wrap_adv", 32'h0, 1, 0, 32'h102, 16'd2);

        // Async reset mid-run takes effect without a clock edge.
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_midrun", 32'h0, 0, 0, 32'h0, 16'd0);
        step();
        rst = 1'b0;

        // Async reset while parked in FAULT.
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        step();
        drive(0, 1, 1, 32'h36, 0, 32'h0);
        step();
        chk_all("fault_enter", 32'h0, 0, 1, 32'h36, 16'd0);
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_fault", 32'h0, 0, 0, 32'h0, 16'd0);
        step();
        rst = 1'b0;

        // Saturation of a 2-bit redirect counter.
        step();
        for (int i = 0; i < 5; i++) begin
            bus2.redirect_valid  = 1'b1;
            bus2.redirect_target = 32'h1000 + 32'(i * 16);
            step();
            chk($sformatf("sat%0d.count", i), 64'(bus2.redirect_count), 64'((i < 3) ? i + 1 : 3));
            chk($sformatf("sat%0d.pc", i), 64'(bus2.pc_out), 64'(32'h1000 + 32'(i * 16)));
        end
        bus2.redirect_valid = 1'b0;

        // Random traffic against the model.
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 7) == 0);
            tv = ($urandom_range(0, 15) == 0);
            rt = $urandom;
            if ($urandom_range(0, 1) == 1) rt = rt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFF8;
            tvec = $urandom;
            drive(st, rd, rv, rt, tv, tvec);
            model_edge(st, rd, rv, longint'(rt), tv, longint'(tvec));
            step();
            chk_all($sformatf("rnd%0d", c), 32'(m_pc), m_v, m_mis, 32'(m_fa), 16'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
